// File: rtl/synchronous_fifo.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty thresholds,
// overflow/underflow pulses and a selectable first-word-fall-through read port.
module synchronous_fifo #(
    parameter int BITSIZE            = 8,
    parameter int MEMSIZE            = 32,
    parameter int ALMOST_FULL_LEVEL  = 28,
    parameter int ALMOST_EMPTY_LEVEL = 4,
    parameter int FWFT               = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      w_enable,
    input  logic                      r_enable,
    input  logic [BITSIZE-1:0]        wdata,
    output logic [BITSIZE-1:0]        rdata,
    output logic                      full,
    output logic                      empty,
    output logic                      almost_full,
    output logic                      almost_empty,
    output logic [$clog2(MEMSIZE):0]  count,
    output logic                      overflow,
    output logic                      underflow
);
    localparam int ADDR = $clog2(MEMSIZE);
    localparam int CNT  = ADDR + 1;

    localparam logic [CNT-1:0] FULL_CNT = CNT'(MEMSIZE);
    localparam logic [CNT-1:0] AF_LVL   = CNT'(ALMOST_FULL_LEVEL);
    localparam logic [CNT-1:0] AE_LVL   = CNT'(ALMOST_EMPTY_LEVEL);

    logic [BITSIZE-1:0] mem [MEMSIZE];
    logic [ADDR-1:0]    wptr;
    logic [ADDR-1:0]    rptr;
    logic               wr;
    logic               rd;
    logic [CNT-1:0]     count_nxt;

    // Accepts use the registered flags; reset blocks every access.
    assign wr = w_enable & ~full  & ~reset;
    assign rd = r_enable & ~empty & ~reset;

    always_comb begin
        count_nxt = count;
        unique case ({wr, rd})
            2'b10:   count_nxt = count + CNT'(1);
            2'b01:   count_nxt = count - CNT'(1);
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr         <= '0;
            rptr         <= '0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (wr) wptr <= wptr + ADDR'(1);
            if (rd) rptr <= rptr + ADDR'(1);
            count        <= count_nxt;
            // Flags follow the next count so they move on the same edge as count.
            full         <= (count_nxt == FULL_CNT);
            empty        <= (count_nxt == '0);
            almost_full  <= (count_nxt >= AF_LVL);
            almost_empty <= (count_nxt <= AE_LVL);
            overflow     <= w_enable & full;
            underflow    <= r_enable & empty;
        end
    end

    always_ff @(posedge clk) begin
        if (wr) mem[wptr] <= wdata;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign rdata = mem[rptr];
        end else begin : g_std
            always_ff @(posedge clk or posedge reset) begin
                if (reset)   rdata <= '0;
                else if (rd) rdata <= mem[rptr];
            end
        end
    endgenerate

endmodule
